// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider: one quotient bit per cycle, signed/unsigned, divide-by-zero short-cut, annul abort.
// Registered {remainder, quotient} is held with ready_o while the requester keeps start_i high.
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               neg1, neg2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     trial;
  logic               qbit;
  logic [WIDTH-1:0]   rem_next, quot_next;
  logic [WIDTH-1:0]   q_fin, r_fin;

  assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
  assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1 = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign mag2 = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

  // dvd_q shifts out dividend bits MSB-first and fills with quotient bits from the LSB.
  assign trial     = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign qbit      = ~trial[WIDTH];
  assign rem_next  = qbit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign quot_next = {dvd_q[WIDTH-2:0], qbit};
  assign q_fin     = qneg_q ? (~quot_next + 1'b1) : quot_next;
  assign r_fin     = rneg_q ? (~rem_next + 1'b1) : rem_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_RUN;
            dvd_d   = mag1;
            dvs_d   = mag2;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = neg1 ^ neg2;
            rneg_d  = neg1;
          end
        end
      end
      S_BYZERO: begin
        state_d  = S_DONE;
        result_d = '0;
        ready_d  = 1'b1;
      end
      S_RUN: begin
        if (annul_i) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end else begin
          dvd_d = quot_next;
          rem_d = rem_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = S_DONE;
            result_d = {r_fin, q_fin};
            ready_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!start_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed divides push expected results, a monitor checks them on ready_o.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div_iter_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          t0_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: every rising ready_o must match the oldest outstanding request.
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    if (ready_o && !ready_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        int l, t;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        t = t0_q.pop_front();
        check("result", result_o, e);
        check("latency", 64'(cyc - t), 64'(l));
      end
    end
    ready_prev = ready_o;
  end

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input int hold, input bit scramble);
    bit seen;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    t0_q.push_back(cyc);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (scramble && i == 5) begin
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'h0000_0003;
        signed_div_i = ~sgn;
      end
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("ready_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      void'(t0_q.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(ready_o), 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  task automatic expect_quiet(input string name, input int n);
    bit rose;
    rose = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ready_o) rose = 1'b1;
    end
    check(name, 64'(rose), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b1;
    expect_quiet("idle_quiet", 3);

    do_div(1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33, 0, 1'b0);
    do_div(1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 0, 1'b0);
    do_div(1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0, 1'b0);
    do_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, 0, 1'b0);
    do_div(1'b0, 32'h12345678,   32'd0,        64'h0,                 2,  5, 1'b0);
    do_div(1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33, 2, 1'b0);
    do_div(1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33, 0, 1'b0);
    do_div(1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33, 0, 1'b0);
    do_div(1'b0, 32'd3,          32'd5,        64'h00000003_00000000, 33, 0, 1'b0);

    // Annul in RUN cycle 10: no result may appear.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    expect_quiet("annul_no_ready", 40);
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0, 1'b0);

    // Start and annul together in IDLE: annul wins.
    @(negedge clk);
    start_i = 1'b1;
    annul_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    expect_quiet("start_annul_idle", 40);

    // Reset in RUN cycle 15.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_ready", 64'(ready_o), 64'd0);
    check("midrun_reset_result", result_o, 64'd0);
    rst     = 1'b1;
    start_i = 1'b0;
    expect_quiet("after_reset_quiet", 40);

    // Operands changed mid-RUN must not affect the latched divide.
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1, 1'b1);
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring divider for the execute stage's DIV/DIVU path; it is the responder side of the start/ready divide handshake.
- Latches operands on start, iterates one quotient bit per cycle, then presents a registered {remainder, quotient} with ready until the requester drops start.
- Supports signed/unsigned operation, divide-by-zero short-cut and annul abort.

Parameters:
WIDTH, 32, operand width; result_o is 2*WIDTH.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-low: rst==0 at a rising edge resets the block
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  request; held high by requester until ready_o seen
annul_i  input  1  abort current operation
result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}
ready_o  output  1  result valid

Behaviour:
- Reset (rst==0 at clk edge, any state, including mid-RUN): state=IDLE, ready_o=0, result_o=0, iteration counter=0, operand latches=0.
- States: IDLE, BYZERO, RUN, DONE. All outputs are registered.
- IDLE
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> RUN.
  - On entry to RUN: latch signed_div_i and operand magnitudes. When signed, negative operands are two's-complement negated. Record quotient sign = sign1 XOR sign2 and remainder sign = sign1. Clear counter.
  - Otherwise stay in IDLE.
- BYZERO: next state DONE with result_o=0.
- RUN
  - One iteration per cycle: shift partial remainder left by 1 bit, bring in the next dividend bit (MSB first), subtract the divisor magnitude.
  - Non-negative difference -> keep the difference, quotient bit 1; otherwise restore, quotient bit 0.
  - Counter increments each iteration. After iteration WIDTH, go to DONE.
  - annul_i=1 in any RUN cycle -> IDLE next edge, ready_o stays 0, result_o unchanged (0).
- Result on entering DONE
  - Quotient negated if the quotient sign is set (signed only).
  - Remainder negated if the remainder sign is set (signed only).
  - result_o loaded; ready_o=1.
- DONE
  - start_i=0 -> IDLE next edge, ready_o=0, result_o=0.
  - start_i=1 -> hold DONE with result_o and ready_o stable.
  - annul_i is ignored in DONE.
- Latency: with the start cycle as cycle 0 (start sampled at end of cycle 0):
  - Normal divide: RUN during cycles 1..32; ready_o=1 first in cycle 33.
  - Divide-by-zero: BYZERO in cycle 1; ready_o=1 in cycle 2.
- Operand inputs are ignored after latching; changes during RUN have no effect.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap, no exception).
- Simultaneous start_i and annul_i in IDLE: annul wins, stay IDLE.
- The block never asserts ready_o without a preceding accepted start.

Test Plan:
- Unsigned 100/7: start=1, signed=0, op1=0x00000064, op2=0x00000007 -> ready_o=1 in cycle 33, result_o=0x00000002_0000000E; drop start -> next cycle ready_o=0, result_o=0.
- Signed -7/2: op1=0xFFFFFFF9, op2=0x00000002, signed=1 -> cycle 33 result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero: op1=0x12345678, op2=0 -> ready_o=1 in cycle 2, result_o=0; holding start high for 5 cycles keeps ready_o=1; dropping start returns to IDLE.
- Corner cases:
  - Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000.
  - Unsigned 0xFFFFFFFF/0x00000001 -> 0x00000000_FFFFFFFF.
  - Unsigned 0x00000003/0x00000005 -> 0x00000003_00000000.
- Annul then restart: annul_i=1 in cycle 10 of RUN -> IDLE in cycle 11, ready_o never rises. New start with 100/7 -> correct result 33 cycles later.
- Reset mid-operation: rst=0 in cycle 15 of RUN -> next cycle ready_o=0, result_o=0, IDLE. After rst=1, change operands during RUN -> result reflects the originally latched operands only.
